stopwatch_timer_core: RTL and testbench

STOPWATCH_TIMER_CORE -- requirements
Module: stopwatch_timer_core

---
 rtl/stopwatch_timer_core_if.sv | 36 +++
 rtl/stopwatch_timer_core.sv | 161 ++++++++++++++++
 tb/tb_stopwatch_timer_core.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_timer_core_if.sv
// Control, preset and time-field bundle for stopwatch_timer_core.
// master drives run/clear/mode/load/ld_*; slave (the core) drives the time fields and status.
interface stopwatch_timer_core_if #(
  parameter int SUB_COUNT  = 100,
  parameter int HOUR_COUNT = 24
);
  localparam int SW = $clog2(SUB_COUNT);
  localparam int HW = $clog2(HOUR_COUNT);

  logic          run;
  logic          clear;
  logic          mode;
  logic          load;
  logic [HW-1:0] ld_hour;
  logic [5:0]    ld_min;
  logic [5:0]    ld_sec;

  logic [SW-1:0] sub;
  logic [5:0]    sec;
  logic [5:0]    min;
  logic [HW-1:0] hour;
  logic          tick;
  logic          rollover;
  logic          done;
  logic          expired;

  modport master (
    output run, clear, mode, load, ld_hour, ld_min, ld_sec,
    input  sub, sec, min, hour, tick, rollover, done, expired
  );

  modport slave (
    input  run, clear, mode, load, ld_hour, ld_min, ld_sec,
    output sub, sec, min, hour, tick, rollover, done, expired
  );
endinterface

// File: rtl/stopwatch_timer_core.sv
// Stopwatch / countdown timer: prescaled sub-second steps with a full
// single-edge carry/borrow ripple through sub, sec, min and hour.
module stopwatch_timer_core #(
  parameter int TICK_DIV   = 1_000_000,
  parameter int SUB_COUNT  = 100,
  parameter int HOUR_COUNT = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  stopwatch_timer_core_if.slave bus
);
  localparam int SW = $clog2(SUB_COUNT);
  localparam int HW = $clog2(HOUR_COUNT);
  localparam int PW = $clog2(TICK_DIV);

  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SUB_MAX  = SW'(SUB_COUNT - 1);
  localparam logic [HW-1:0] HOUR_MAX = HW'(HOUR_COUNT - 1);
  localparam logic [5:0]    SIX_MAX  = 6'd59;

  logic [PW-1:0] pre_q;
  logic [SW-1:0] sub_q;
  logic [5:0]    sec_q;
  logic [5:0]    min_q;
  logic [HW-1:0] hour_q;
  logic          tick_q;
  logic          rollover_q;
  logic          done_q;
  logic          expired_q;

  logic          counting;
  logic          step;

  logic [SW-1:0] up_sub, dn_sub;
  logic [5:0]    up_sec, dn_sec;
  logic [5:0]    up_min, dn_min;
  logic [HW-1:0] up_hour, dn_hour;
  logic          up_wrap;
  logic          now_zero;
  logic          dn_zero;

  logic [HW-1:0] sat_hour;
  logic [5:0]    sat_min;
  logic [5:0]    sat_sec;

  assign counting = bus.run && !expired_q;
  assign step     = counting && (pre_q == PRE_MAX);

  // Next values for one step in each direction; selected by mode at the register.
  always_comb begin
    logic sub_top, sec_top, min_top, hour_top;
    logic sub_bot, sec_bot, min_bot, hour_bot;

    sub_top  = (sub_q  == SUB_MAX);
    sec_top  = (sec_q  == SIX_MAX);
    min_top  = (min_q  == SIX_MAX);
    hour_top = (hour_q == HOUR_MAX);
    sub_bot  = (sub_q  == '0);
    sec_bot  = (sec_q  == '0);
    min_bot  = (min_q  == '0);
    hour_bot = (hour_q == '0);

    up_sub  = sub_top ? '0 : sub_q + SW'(1);
    up_sec  = sec_q;
    up_min  = min_q;
    up_hour = hour_q;
    if (sub_top) up_sec = sec_top ? '0 : sec_q + 6'd1;
    if (sub_top && sec_top) up_min = min_top ? '0 : min_q + 6'd1;
    if (sub_top && sec_top && min_top) up_hour = hour_top ? '0 : hour_q + HW'(1);
    up_wrap = sub_top && sec_top && min_top && hour_top;

    dn_sub  = sub_bot ? SUB_MAX : sub_q - SW'(1);
    dn_sec  = sec_q;
    dn_min  = min_q;
    dn_hour = hour_q;
    if (sub_bot) dn_sec = sec_bot ? SIX_MAX : sec_q - 6'd1;
    if (sub_bot && sec_bot) dn_min = min_bot ? SIX_MAX : min_q - 6'd1;
    if (sub_bot && sec_bot && min_bot) dn_hour = hour_bot ? HOUR_MAX : hour_q - HW'(1);

    now_zero = sub_bot && sec_bot && min_bot && hour_bot;
    dn_zero  = (dn_sub == '0) && (dn_sec == '0) && (dn_min == '0) && (dn_hour == '0);
  end

  // Preset saturation; the extra bit keeps the hour compare exact when HOUR_COUNT is a power of two.
  always_comb begin
    sat_hour = bus.ld_hour;
    sat_min  = bus.ld_min;
    sat_sec  = bus.ld_sec;
    if ({1'b0, bus.ld_hour} >= (HW+1)'(HOUR_COUNT)) sat_hour = HOUR_MAX;
    if (bus.ld_min > SIX_MAX) sat_min = SIX_MAX;
    if (bus.ld_sec > SIX_MAX) sat_sec = SIX_MAX;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q      <= '0;
      sub_q      <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hour_q     <= '0;
      tick_q     <= 1'b0;
      rollover_q <= 1'b0;
      done_q     <= 1'b0;
      expired_q  <= 1'b0;
    end else begin
      tick_q     <= 1'b0;
      rollover_q <= 1'b0;
      done_q     <= 1'b0;
      if (bus.clear) begin
        pre_q     <= '0;
        sub_q     <= '0;
        sec_q     <= '0;
        min_q     <= '0;
        hour_q    <= '0;
        expired_q <= 1'b0;
      end else if (bus.load) begin
        pre_q     <= '0;
        sub_q     <= '0;
        sec_q     <= sat_sec;
        min_q     <= sat_min;
        hour_q    <= sat_hour;
        expired_q <= 1'b0;
      end else begin
        if (counting) pre_q <= step ? '0 : pre_q + PW'(1);
        if (!bus.mode) expired_q <= 1'b0;
        if (step) begin
          if (!bus.mode) begin
            tick_q     <= 1'b1;
            rollover_q <= up_wrap;
            sub_q      <= up_sub;
            sec_q      <= up_sec;
            min_q      <= up_min;
            hour_q     <= up_hour;
          end else if (now_zero) begin
            // Already at zero: halt instead of wrapping, no step applied.
            expired_q <= 1'b1;
          end else begin
            tick_q <= 1'b1;
            sub_q  <= dn_sub;
            sec_q  <= dn_sec;
            min_q  <= dn_min;
            hour_q <= dn_hour;
            if (dn_zero) begin
              done_q    <= 1'b1;
              expired_q <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign bus.sub      = sub_q;
  assign bus.sec      = sec_q;
  assign bus.min      = min_q;
  assign bus.hour     = hour_q;
  assign bus.tick     = tick_q;
  assign bus.rollover = rollover_q;
  assign bus.done     = done_q;
  assign bus.expired  = expired_q;
endmodule

// File: tb/tb_stopwatch_timer_core.sv
// Directed bench for stopwatch_timer_core with TICK_DIV=4, SUB_COUNT=10, HOUR_COUNT=3.
module tb_stopwatch_timer_core;
  localparam int TICK_DIV   = 4;
  localparam int SUB_COUNT  = 10;
  localparam int HOUR_COUNT = 3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   ticks;

  stopwatch_timer_core_if #(.SUB_COUNT(SUB_COUNT), .HOUR_COUNT(HOUR_COUNT)) bus ();

  stopwatch_timer_core #(
    .TICK_DIV(TICK_DIV), .SUB_COUNT(SUB_COUNT), .HOUR_COUNT(HOUR_COUNT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s, input int sb);
    check({tag, ".hour"}, 32'(bus.hour), 32'(h));
    check({tag, ".min"},  32'(bus.min),  32'(m));
    check({tag, ".sec"},  32'(bus.sec),  32'(s));
    check({tag, ".sub"},  32'(bus.sub),  32'(sb));
  endtask

  task automatic check_flags(input string tag, input logic t, input logic r, input logic d, input logic e);
    check({tag, ".tick"},     32'(bus.tick),     32'(t));
    check({tag, ".rollover"}, 32'(bus.rollover), 32'(r));
    check({tag, ".done"},     32'(bus.done),     32'(d));
    check({tag, ".expired"},  32'(bus.expired),  32'(e));
  endtask

  // driver tasks: inputs change only on the falling edge
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cycle();
      if (bus.tick) ticks++;
    end
  endtask

  task automatic do_load(input int h, input int m, input int s);
    bus.ld_hour = 2'(h);
    bus.ld_min  = 6'(m);
    bus.ld_sec  = 6'(s);
    bus.load    = 1'b1;
    cycle();
    bus.load    = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    cycle();
    bus.clear = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ticks  = 0;
    rst         = 1'b1;
    bus.run     = 1'b0;
    bus.clear   = 1'b0;
    bus.mode    = 1'b0;
    bus.load    = 1'b0;
    bus.ld_hour = '0;
    bus.ld_min  = '0;
    bus.ld_sec  = '0;
    repeat (3) @(negedge clk);
    check_time("reset", 0, 0, 0, 0);
    check_flags("reset", 0, 0, 0, 0);
    rst = 1'b0;

    // up count from reset: tick on every 4th cycle
    bus.run = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      cycle();
      check($sformatf("up_tick_c%0d", c), 32'(bus.tick), 32'((c % 4) == 0));
      if (c == 36) check_time("up_c36", 0, 0, 0, 9);
    end
    check_time("up_c40", 0, 0, 1, 0);

    // rollover from 2:59:59.9
    bus.run = 1'b0;
    do_load(2, 59, 59);
    check_time("ld_2_59_59", 2, 59, 59, 0);
    bus.run = 1'b1;
    run_cycles(36);
    check_time("pre_roll", 2, 59, 59, 9);
    run_cycles(3);
    check("pre_roll.rollover", 32'(bus.rollover), 32'd0);
    cycle();
    check_time("roll", 0, 0, 0, 0);
    check_flags("roll", 1, 1, 0, 0);
    cycle();
    check("roll_after.rollover", 32'(bus.rollover), 32'd0);

    // countdown from 0:00:01 to expiry
    bus.run  = 1'b0;
    bus.mode = 1'b1;
    do_load(0, 0, 1);
    bus.run = 1'b1;
    run_cycles(4);
    check_time("dn_first", 0, 0, 0, 9);
    run_cycles(35);
    check_time("dn_c39", 0, 0, 0, 1);
    check("dn_c39.done", 32'(bus.done), 32'd0);
    cycle();
    check_time("dn_zero", 0, 0, 0, 0);
    check_flags("dn_zero", 1, 0, 1, 1);
    cycle();
    check("dn_zero_after.done", 32'(bus.done), 32'd0);
    check("dn_zero_after.expired", 32'(bus.expired), 32'd1);
    ticks = 0;
    run_cycles(40);
    check("expired_ticks", 32'(ticks), 32'd0);
    check_time("expired_hold", 0, 0, 0, 0);
    bus.mode = 1'b0;
    cycle();
    check("up_clears_expired", 32'(bus.expired), 32'd0);

    // down from 0:01:00.0: single borrow ripple
    bus.run  = 1'b0;
    bus.mode = 1'b1;
    do_load(0, 1, 0);
    bus.run = 1'b1;
    run_cycles(4);
    check_time("dn_borrow", 0, 0, 59, 9);

    // down at zero without a prior done: halt, no done
    bus.run = 1'b0;
    do_clear();
    bus.run = 1'b1;
    run_cycles(4);
    check_time("dn_at_zero", 0, 0, 0, 0);
    check_flags("dn_at_zero", 0, 0, 0, 1);

    // pause keeps partial prescaler period
    bus.run  = 1'b0;
    bus.mode = 1'b0;
    do_clear();
    bus.run = 1'b1;
    run_cycles(2);
    bus.run = 1'b0;
    ticks = 0;
    run_cycles(20);
    check("pause_ticks", 32'(ticks), 32'd0);
    bus.run = 1'b1;
    cycle();
    check("resume_c1.tick", 32'(bus.tick), 32'd0);
    cycle();
    check("resume_c2.tick", 32'(bus.tick), 32'd1);
    check_time("resume", 0, 0, 0, 1);

    // clear+load coincident with a step: clear wins, step discarded
    bus.run = 1'b0;
    do_load(1, 2, 3);
    bus.run = 1'b1;
    run_cycles(3);
    bus.clear = 1'b1;
    do_load(2, 4, 5);
    bus.clear = 1'b0;
    check_time("clr_ld_step", 0, 0, 0, 0);
    check_flags("clr_ld_step", 0, 0, 0, 0);
    // load coincident with a step, with saturation
    run_cycles(3);
    do_load(3, 61, 63);
    check_time("ld_sat", 2, 59, 59, 0);
    check("ld_sat.tick", 32'(bus.tick), 32'd0);

    // asynchronous reset mid-run
    run_cycles(6);
    check_time("pre_rst", 2, 59, 59, 1);
    #2 rst = 1'b1;
    #1;
    check_time("async_rst", 0, 0, 0, 0);
    check_flags("async_rst", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      cycle();
      check($sformatf("post_rst_tick_c%0d", c), 32'(bus.tick), 32'(c == 4));
    end
    check_time("post_rst", 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
